// File: rtl/compuertas_pkg.sv
// Shared op-codes and FSM encoding for the parametrised gate block.
package compuertas_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_BUF  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        BARRIDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

endpackage

// File: rtl/compuertas_param_nucleo.sv
// Combinational N-input bitwise gate; each bit lane reduces the N_ENT inputs independently.
module compuerta_nucleo
    import compuertas_pkg::*;
#(
    parameter int N_ENT = 3,
    parameter int ANCHO = 1
) (
    input  logic [N_ENT*ANCHO-1:0] ent,
    input  logic [2:0]             sel,
    output logic [ANCHO-1:0]       result
);

    logic [N_ENT-1:0] lane;

    always_comb begin
        result = '0;
        lane   = '0;
        for (int b = 0; b < ANCHO; b++) begin
            for (int i = 0; i < N_ENT; i++) begin
                lane[i] = ent[i*ANCHO + b];
            end
            case (sel)
                OP_AND:  result[b] = &lane;
                OP_OR:   result[b] = |lane;
                OP_NAND: result[b] = ~&lane;
                OP_NOR:  result[b] = ~|lane;
                OP_XOR:  result[b] = ^lane;
                OP_XNOR: result[b] = ~^lane;
                OP_BUF:  result[b] = lane[0];
                OP_NOT:  result[b] = ~lane[0];
                default: result[b] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/compuertas_param.sv
// Registered selectable gate with handshake plus a self-characterising truth-table sweep.
module compuertas_param
    import compuertas_pkg::*;
#(
    parameter int N_ENT = 3,
    parameter int ANCHO = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   act,
    input  logic [2:0]             sel,
    input  logic [N_ENT*ANCHO-1:0] ent,
    input  logic                   ent_valido,
    output logic [ANCHO-1:0]       sal,
    output logic                   sal_valida,
    input  logic                   barrido_ini,
    output logic                   barrido_ocupado,
    output logic [2**N_ENT-1:0]    tabla,
    output logic                   tabla_lista
);

    estado_t          estado, estado_sig;
    logic [N_ENT-1:0] cnt;
    logic [2:0]       sel_b;
    logic [ANCHO-1:0] res_n;
    logic             res_b;
    logic             fin_cuenta;

    // Sweep core sees the counter as N_ENT one-bit inputs: input i = counter bit i.
    compuerta_nucleo #(.N_ENT(N_ENT), .ANCHO(ANCHO)) u_normal (
        .ent    (ent),
        .sel    (sel),
        .result (res_n)
    );

    compuerta_nucleo #(.N_ENT(N_ENT), .ANCHO(1)) u_barrido (
        .ent    (cnt),
        .sel    (sel_b),
        .result (res_b)
    );

    assign fin_cuenta      = (cnt == '1);
    assign barrido_ocupado = (estado != REPOSO);

    always_ff @(posedge clk) begin
        if (rst) estado <= REPOSO;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (act && barrido_ini) estado_sig = BARRIDO;
            BARRIDO: begin
                if (!act)           estado_sig = REPOSO;
                else if (fin_cuenta) estado_sig = FIN;
            end
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sal         <= '0;
            sal_valida  <= 1'b0;
            tabla       <= '0;
            tabla_lista <= 1'b0;
            cnt         <= '0;
            sel_b       <= '0;
        end else begin
            sal_valida  <= 1'b0;
            tabla_lista <= 1'b0;
            case (estado)
                REPOSO: begin
                    // A sweep request takes priority over a same-cycle evaluation.
                    if (act && barrido_ini) begin
                        sel_b <= sel;
                        tabla <= '0;
                        cnt   <= '0;
                    end else if (act && ent_valido) begin
                        sal        <= res_n;
                        sal_valida <= 1'b1;
                    end
                end
                BARRIDO: begin
                    if (!act) begin
                        tabla <= '0;
                        cnt   <= '0;
                    end else begin
                        tabla[cnt] <= res_b;
                        cnt        <= fin_cuenta ? '0 : cnt + 1'b1;
                    end
                end
                FIN:     tabla_lista <= act;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compuertas_param.sv
// Randomised and directed bench for compuertas_param against a cycle-level behavioural model.
module tb_compuertas_param;

    localparam int N  = 3;
    localparam int W  = 4;
    localparam int NC = 2**N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           act = 1'b0;
    logic [2:0]     sel = 3'b000;
    logic [N*W-1:0] ent = '0;
    logic           ent_valido = 1'b0;
    logic [W-1:0]   sal;
    logic           sal_valida;
    logic           barrido_ini = 1'b0;
    logic           barrido_ocupado;
    logic [NC-1:0]  tabla;
    logic           tabla_lista;

    compuertas_param #(.N_ENT(N), .ANCHO(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .act             (act),
        .sel             (sel),
        .ent             (ent),
        .ent_valido      (ent_valido),
        .sal             (sal),
        .sal_valida      (sal_valida),
        .barrido_ini     (barrido_ini),
        .barrido_ocupado (barrido_ocupado),
        .tabla           (tabla),
        .tabla_lista     (tabla_lista)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Gate output from the count of ones among the inputs of a lane.
    function automatic logic gate_bit(input logic [N-1:0] bits, input logic [2:0] s);
        int ones = 0;
        for (int i = 0; i < N; i++) ones += int'(bits[i]);
        case (s)
            3'd0: return ones == N;
            3'd1: return ones != 0;
            3'd2: return ones != N;
            3'd3: return ones == 0;
            3'd4: return (ones % 2) == 1;
            3'd5: return (ones % 2) == 0;
            3'd6: return bits[0];
            default: return !bits[0];
        endcase
    endfunction

    function automatic logic [W-1:0] gate_word(input logic [N*W-1:0] e, input logic [2:0] s);
        logic [W-1:0] r;
        logic [N-1:0] bits;
        for (int b = 0; b < W; b++) begin
            for (int i = 0; i < N; i++) bits[i] = e[i*W + b];
            r[b] = gate_bit(bits, s);
        end
        return r;
    endfunction

    // Model: pos = -1 idle, 0..NC-1 next table entry to write, NC = completion cycle.
    logic [W-1:0]  m_sal;
    logic          m_valida;
    logic [NC-1:0] m_tabla;
    logic          m_lista;
    logic [2:0]    m_sel_b;
    int            m_pos = -1;

    always @(posedge clk) begin
        logic nv, nl;
        nv = 1'b0;
        nl = 1'b0;
        if (rst) begin
            m_sal = '0; m_tabla = '0; m_sel_b = '0; m_pos = -1;
        end else if (m_pos < 0) begin
            if (act && barrido_ini) begin
                m_sel_b = sel; m_tabla = '0; m_pos = 0;
            end else if (act && ent_valido) begin
                m_sal = gate_word(ent, sel); nv = 1'b1;
            end
        end else if (m_pos < NC) begin
            if (!act) begin
                m_pos = -1; m_tabla = '0;
            end else begin
                m_tabla[m_pos] = gate_bit(N'(m_pos), m_sel_b);
                m_pos++;
            end
        end else begin
            nl = act;
            m_pos = -1;
        end
        m_valida = nv;
        m_lista  = nl;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("sal", 32'(sal), 32'(m_sal));
            check("sal_valida", 32'(sal_valida), 32'(m_valida));
            check("barrido_ocupado", 32'(barrido_ocupado), 32'(m_pos >= 0));
            check("tabla", 32'(tabla), 32'(m_tabla));
            check("tabla_lista", 32'(tabla_lista), 32'(m_lista));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input logic [N*W-1:0] e, input logic [2:0] s);
        ent = e; sel = s; ent_valido = 1'b1;
        step();
        ent_valido = 1'b0;
    endtask

    task automatic run_sweep(input logic [2:0] s, input logic [2:0] s_mid,
                             output int busy_n, output int lista_n);
        sel = s; barrido_ini = 1'b1;
        step();
        barrido_ini = 1'b0;
        busy_n = 0; lista_n = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 3) sel = s_mid;
            if (barrido_ocupado) busy_n++;
            if (tabla_lista) lista_n++;
            step();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sal"}, 32'(sal), 0);
        check({tag, "_sal_valida"}, 32'(sal_valida), 0);
        check({tag, "_ocupado"}, 32'(barrido_ocupado), 0);
        check({tag, "_tabla"}, 32'(tabla), 0);
        check({tag, "_tabla_lista"}, 32'(tabla_lista), 0);
    endtask

    initial begin
        int bn, ln;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_on = 1'b1;
        check_zero("reset");
        act = 1'b1;

        run_sweep(3'b000, 3'b000, bn, ln);
        check("and_busy_cycles", 32'(bn), 9);
        check("and_lista_pulses", 32'(ln), 1);
        check("and_tabla", 32'(tabla), 32'h80);

        run_sweep(3'b100, 3'b000, bn, ln);
        check("xor_tabla_sel_changed", 32'(tabla), 32'h96);
        run_sweep(3'b011, 3'b011, bn, ln);
        check("nor_tabla", 32'(tabla), 32'h01);

        eval(12'hCA6, 3'b001);
        check("or_sal", 32'(sal), 32'hE);
        check("or_valida", 32'(sal_valida), 1);
        step();
        check("valida_single", 32'(sal_valida), 0);
        eval(12'hCA6, 3'b100);
        check("xor_sal", 32'(sal), 32'h0);
        eval(12'hCA6, 3'b111);
        check("not_sal", 32'(sal), 32'h9);

        ent = 12'h123; sel = 3'b000; ent_valido = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("b2b_valida", 32'(sal_valida), 1);
        end
        ent_valido = 1'b0;
        eval(12'hCA6, 3'b111);

        act = 1'b0; ent_valido = 1'b1; barrido_ini = 1'b1; ent = 12'hFFF; sel = 3'b000;
        step(); step();
        check("act0_valida", 32'(sal_valida), 0);
        check("act0_ocupado", 32'(barrido_ocupado), 0);
        check("act0_sal_held", 32'(sal), 32'h9);
        ent_valido = 1'b0; barrido_ini = 1'b0; act = 1'b1;

        sel = 3'b000; barrido_ini = 1'b1;
        step();
        barrido_ini = 1'b0;
        for (int k = 0; k < 4; k++) step();
        act = 1'b0;
        step();
        check("abort_ocupado", 32'(barrido_ocupado), 0);
        check("abort_tabla", 32'(tabla), 0);
        check("abort_lista", 32'(tabla_lista), 0);
        act = 1'b1;
        run_sweep(3'b101, 3'b101, bn, ln);
        check("after_abort_xnor_tabla", 32'(tabla), 32'h69);
        check("after_abort_lista", 32'(ln), 1);

        sel = 3'b001; barrido_ini = 1'b1;
        step();
        barrido_ini = 1'b0;
        step(); step();
        eval(12'hFFF, 3'b001);
        check("busy_req_ignored", 32'(sal_valida), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_rst");

        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            act         = ($urandom_range(0, 19) != 0);
            ent_valido  = $urandom_range(0, 1);
            barrido_ini = ($urandom_range(0, 15) == 0);
            sel         = 3'($urandom_range(0, 7));
            ent         = 12'($urandom);
            step();
        end
        rst = 1'b0; act = 1'b1; ent_valido = 1'b0; barrido_ini = 1'b0;
        for (int k = 0; k < 12; k++) step();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/compuertas_param.md
Name: compuertas_param

Overview:
- Parametrised, registered successor to the 3-input selectable logic-gate unit: N_ENT inputs, each ANCHO bits wide, with one of 8 bitwise gate operations selected by `sel`.
- Adds a handshake for registered evaluation.
- Adds a hardware truth-table sweep: on request, an internal counter drives all 2^N_ENT input combinations through the selected gate and captures the 1-bit results into `tabla`.
- Sits in the logic-test area as a self-characterising gate block.

Parameters:
- N_ENT, 3, number of gate inputs; legal range 2..6.
- ANCHO, 1, bit width of each input and of `sal`; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- act  in  1  block enable; 0 forces idle and output invalid.
- sel  in  3  operation: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 BUF(ent lane 0), 111 NOT(ent lane 0).
- ent  in  N_ENT*ANCHO  packed inputs; input i occupies bits [i*ANCHO +: ANCHO].
- ent_valido  in  1  request evaluation of `ent` this cycle.
- sal  out  ANCHO  registered gate result.
- sal_valida  out  1  one-cycle pulse; `sal` holds a new result.
- barrido_ini  in  1  start truth-table sweep (pulse).
- barrido_ocupado  out  1  high while a sweep is running.
- tabla  out  2^N_ENT  sweep result; bit k = gate output for combination k.
- tabla_lista  out  1  one-cycle pulse when `tabla` is complete.

Behaviour:
- Reset (rst=1 at a clock edge): sal=0, sal_valida=0, barrido_ocupado=0, tabla=0, tabla_lista=0, counter=0, FSM=REPOSO. Reset overrides every other input.
- Gate function:
  - Bitwise across the N_ENT inputs, per bit lane. XOR/XNOR are N-input parity / inverted parity.
  - BUF and NOT use input 0 only.
- Normal mode (FSM=REPOSO, act=1, ent_valido=1):
  - `sal` is registered with the result of ent and sel sampled in cycle t.
  - sal_valida=1 in cycle t+1 only; latency 1; back-to-back requests give back-to-back pulses.
  - Without ent_valido, `sal` holds its value and sal_valida=0.
- act=0: sal_valida=0 and tabla_lista=0. `sal` holds its value. ent_valido and barrido_ini are ignored.
- FSM states: REPOSO, BARRIDO, FIN.
- REPOSO -> BARRIDO: on act=1 and barrido_ini=1. In that cycle:
  - latch sel into sel_b; clear tabla to 0; set counter=0.
  - If barrido_ini and ent_valido are both high, the sweep wins and the evaluation request is dropped (no sal_valida).
- BARRIDO, each cycle:
  - Evaluate sel_b with input i = counter bit i (lane 0 only; other lanes are don't-care).
  - Write the result into tabla[counter], then increment counter.
  - On counter = 2^N_ENT-1, go to FIN after the write.
  - Duration is exactly 2^N_ENT cycles.
- FIN: tabla_lista=1 for one cycle, then REPOSO. `tabla` holds until the next sweep start or reset.
- barrido_ocupado=1 in BARRIDO and FIN.
- Busy behaviour: ent_valido and barrido_ini are ignored while busy. sel changes during a sweep have no effect because sel_b is latched.
- Timing: with barrido_ini accepted at edge t, tabla_lista is high in the cycle after edge t+2^N_ENT+1.
- act dropped during BARRIDO: abort to REPOSO next edge; tabla cleared to 0; no tabla_lista; counter=0.
- rst mid-sweep: same as full reset.
- Counter width is N_ENT; the terminal count is compared explicitly, so there is no wrap in BARRIDO.

Decomposition:
- Package compuertas_pkg:
  - 3-bit op-code constants (OP_AND .. OP_NOT).
  - FSM state encoding (REPOSO, BARRIDO, FIN).
- One combinational sub-module, compuerta_nucleo (params N_ENT, ANCHO): inputs ent and sel, output result.
  - Instantiated twice: once ANCHO-wide for normal mode, once with ANCHO=1 fed by the counter for the sweep.
- The FSM, counter and registers live in the top module.

Test Plan:
- N_ENT=3, ANCHO=1, sel=000 (AND), pulse barrido_ini -> barrido_ocupado high for 9 cycles; tabla_lista pulses once; tabla=8'b1000_0000.
- Same configuration, sel=100 (XOR) sweep -> tabla=8'b1001_0110; sel=011 (NOR) sweep -> tabla=8'b0000_0001; sel changed mid-sweep has no effect.
- N_ENT=3, ANCHO=4, ent={4'hC,4'hA,4'h6}, ent_valido one cycle:
  - sel=001 -> sal=4'hE with sal_valida one cycle later.
  - sel=100 -> sal=4'h0.
  - sel=111 -> sal=4'h9.
  - Three consecutive requests -> three consecutive pulses.
- act=0 with ent_valido=1 and barrido_ini=1 -> no sal_valida, no sweep, sal unchanged.
- Sweep started, act dropped after 4 cycles -> next cycle barrido_ocupado=0, tabla=0, no tabla_lista; a new sweep then completes normally.
- rst asserted mid-sweep, and ent_valido pulsed during a sweep -> all outputs 0 after reset edge; ignored request produces no sal_valida.
